spi_rx_mmio_receiver: RTL and testbench
=======================================

# spi_rx_mmio_receiver

Memory-mapped 128-bit receive path for the AES co-processor link. An 8-lane parallel SPI slave shifts in 16 bytes per chip-select frame. A CPU-side register bank on the PicoRV32 native memory bus latches each completed block and exposes it as four 32-bit data words, a status flag and a maskable interrupt. The block sits between the external SPI pins and the CPU bus, as a peripheral at BASE_ADDR.

## Interface
- BASE_ADDR, 32'h3000_0000: base of the 32-byte register window. Decoded on addr[31:5].
- clk  in  1  system clock (50 MHz nominal); all state is in this domain.
- reset  in  1  asynchronous, active-high reset.
- spi_clk_in  in  1  SPI clock from the master, asynchronous to clk. Data is sampled on its rising edge.
- spi_data_in  in  8  one byte per spi_clk_in rising edge.
- spi_cs_n_in  in  1  active-low frame select.
- mem_valid  in  1  bus request.
- mem_ready  out  1  one-cycle acknowledge.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read, nonzero means write.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- irq_rx  out  1  level interrupt, equal to data_ready AND irq_enable.
- rx_busy  out  1  high while a frame is being received (CS low).

## Operation
- SPI input synchronisation:
  - spi_clk_in, spi_cs_n_in and spi_data_in each pass through a 2-FF synchroniser.
  - A rising edge of spi_clk_in is detected by comparing the synchronised value with its 1-cycle-delayed copy.
  - The synchronised data is captured on the detected edge. The master holds data ≥20 ns before and ≥80 ns after the edge, with each clock phase ≥40 ns.
- Framing:
  - A falling edge of synchronised CS clears the byte counter (0..15) and sets rx_busy.
  - While CS is low, each detected spi_clk rising edge stores the byte into shift[8*i+7 : 8*i], with i = byte count, then increments the count.
  - Byte 0 is the LSB of the 128-bit word (little-endian).
  - On the 16th byte the 128-bit word is complete. An internal rx_valid pulses for 1 cycle and the counter returns to 0.
  - Further bytes in the same frame start a new block.
  - CS rising before 16 bytes discards the partial block: no rx_valid, counter cleared. rx_busy clears on CS rise.
- Receive buffer:
  - On rx_valid the 128-bit word is copied into DATA0..3 and data_ready is set.
  - A new block arriving while data_ready=1 overwrites the data; data_ready stays 1.
- Register map (offset from BASE_ADDR):
  - 0x00 STATUS (RO): bit0 = data_ready; other bits 0.
  - 0x04 DATA0 (RO): bits 31:0.
  - 0x08 DATA1 (RO): bits 63:32.
  - 0x0C DATA2 (RO): bits 95:64.
  - 0x10 DATA3 (RO): bits 127:96.
  - 0x14 CLEAR (WO): any write clears data_ready; reads return 0.
  - 0x18 IRQ_ENABLE (RW): bit0 only; written from wdata[0] when any strobe is set.
  - 0x1C: reads 0, writes ignored.
- Register access rules:
  - Writes to RO registers are ignored.
  - Addresses outside the window are not acknowledged (mem_ready stays 0) and cause no side effects.
- Simultaneous rx_valid and a CLEAR write in the same cycle: set wins, so data_ready=1 with the new data.

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0, irq_rx=0, rx_busy=0.
  - data_ready=0, irq_enable=0, DATA0..3=0, byte counter=0.
  - Synchroniser CS stages reset to 1; other synchroniser stages reset to 0.
- Reset mid-frame aborts the frame; the block then waits for the next CS falling edge.
- Bus handshake:
  - mem_ready and mem_rdata are registered: mem_ready <= mem_valid & in_window & ~mem_ready.
  - This gives a 1-cycle acknowledge in the cycle after mem_valid is sampled.
  - If mem_valid is held high, ready toggles and each ack is a separate access.
  - The write side effect occurs on the same edge that raises mem_ready.
- SPI latency:
  - From spi_clk_in rising to byte captured: 3–4 clk.
  - From the 16th byte capture to rx_valid: 1 clk.
  - From rx_valid to data_ready and irq_rx high: 1 clk.
- CLEAR write: data_ready and irq_rx fall on the acknowledge edge.

## Test plan
- After reset, read 0x3000_0000 → 0x0000_0000; irq_rx=0.
- Write 0x3000_0018 = 1, then read it back → 0x0000_0001.
- Send bytes 5a c5 b4 70 80 b7 cd d8 30 04 7b 6a d8 e0 c4 69 in one CS frame (byte period 100 ns), then wait 200 ns:
  - irq_rx=1 and STATUS=1.
  - DATA0=0x70b4c55a, DATA1=0xd8cdb780, DATA2=0x6a7b0430, DATA3=0x69c4e0d8.
- Write 0x3000_0014 → irq_rx=0 within 1 clk of the ack; STATUS reads 0.
- Second frame with byte0=0xDE and byte15=0xAD → STATUS=1, DATA0[7:0]=0xDE, DATA3[31:24]=0xAD.
- Boundary cases:
  - Frame of 10 bytes then CS high → STATUS stays 0 and the data is unchanged.
  - CLEAR in the same cycle as rx_valid → STATUS=1.
  - Access to 0x3000_0040 → no mem_ready.

Source files
------------

// File: rtl/spi_rx_mmio_receiver_if.sv
// CPU-side native memory bus bundle for the SPI receive peripheral.
// The CPU drives the request half; the peripheral answers with a
// one-cycle acknowledge and read data.
interface spi_rx_mmio_receiver_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/spi_rx_mmio_receiver.sv
// 128-bit SPI receive path with a memory-mapped register bank.
// An 8-lane SPI slave assembles 16 bytes per chip-select frame
// (byte 0 is the least significant byte). Each completed block is
// latched into four 32-bit data registers, raising data_ready and a
// maskable level interrupt. All SPI pins are resynchronised into clk.
module spi_rx_mmio_receiver #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_clk_in,
  input  logic [7:0]                  spi_data_in,
  input  logic                        spi_cs_n_in,
  spi_rx_mmio_receiver_if.slave       bus,
  output logic                        irq_rx,
  output logic                        rx_busy
);

  // Word offsets (addr[4:2]) inside the 32-byte window.
  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_DATA0  = 3'd1;
  localparam logic [2:0] OFF_DATA1  = 3'd2;
  localparam logic [2:0] OFF_DATA2  = 3'd3;
  localparam logic [2:0] OFF_DATA3  = 3'd4;
  localparam logic [2:0] OFF_CLEAR  = 3'd5;
  localparam logic [2:0] OFF_IRQEN  = 3'd6;

  // ---------------------------------------------------------------
  // SPI input synchronisation
  // ---------------------------------------------------------------
  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic [7:0] data_meta_r, data_sync_r;
  logic [1:0] sync_fill_r;
  logic       cs_armed_r;

  // Two-flop synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      data_meta_r <= 8'h00;
      data_sync_r <= 8'h00;
    end else begin
      sclk_meta_r <= spi_clk_in;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      cs_meta_r   <= spi_cs_n_in;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      data_meta_r <= spi_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // The CS synchroniser resets high, so a CS held low through reset would
  // look like a fresh falling edge. Only accept a falling edge after a
  // genuinely sampled high level, so a frame cut by reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_fill_r <= 2'b00;
      cs_armed_r  <= 1'b0;
    end else begin
      sync_fill_r <= {sync_fill_r[0], 1'b1};
      if (sync_fill_r[1] && cs_sync_r) begin
        cs_armed_r <= 1'b1;
      end else begin
        cs_armed_r <= cs_armed_r;
      end
    end
  end

  logic sclk_rise_s;
  logic cs_fall_s;
  logic cs_rise_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign cs_fall_s   = cs_armed_r & cs_prev_r & ~cs_sync_r;
  assign cs_rise_s   = cs_sync_r & ~cs_prev_r;

  // ---------------------------------------------------------------
  // Framing: byte counter, 128-bit assembly register, block strobe
  // ---------------------------------------------------------------
  logic [3:0]   byte_cnt_r;
  logic [127:0] shift_r;
  logic         rx_valid_r;
  logic         rx_busy_r;
  logic [6:0]   byte_lsb_s;

  assign byte_lsb_s = {byte_cnt_r, 3'b000};

  // Assemble bytes little-endian; pulse rx_valid once per 16 bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_r <= 4'd0;
      shift_r    <= 128'd0;
      rx_valid_r <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (cs_fall_s) begin
        byte_cnt_r <= 4'd0;
        rx_busy_r  <= 1'b1;
      end else if (cs_rise_s) begin
        // A partial block is simply dropped: no strobe, counter cleared.
        byte_cnt_r <= 4'd0;
        rx_busy_r  <= 1'b0;
      end else if (rx_busy_r && !cs_sync_r && sclk_rise_s) begin
        shift_r[byte_lsb_s +: 8] <= data_sync_r;
        if (byte_cnt_r == 4'd15) begin
          byte_cnt_r <= 4'd0;
          rx_valid_r <= 1'b1;
        end else begin
          byte_cnt_r <= byte_cnt_r + 4'd1;
        end
      end else begin
        byte_cnt_r <= byte_cnt_r;
        rx_busy_r  <= rx_busy_r;
      end
    end
  end

  // ---------------------------------------------------------------
  // Register bank on the native memory bus
  // ---------------------------------------------------------------
  logic         in_window_s;
  logic         access_s;
  logic         write_s;
  logic [2:0]   offset_s;
  logic         mem_ready_r;
  logic [31:0]  mem_rdata_r;
  logic [127:0] data_r;
  logic         data_ready_r;
  logic         irq_en_r;
  logic         irq_rx_r;
  logic         data_ready_nx_s;
  logic         irq_en_nx_s;
  logic [31:0]  rdata_nx_s;
  logic         unused_s;

  assign in_window_s = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
  // mem_ready toggles when valid is held, so every ack is a fresh access.
  assign access_s    = bus.mem_valid & in_window_s & ~mem_ready_r;
  assign write_s     = access_s & (bus.mem_wstrb != 4'b0000);
  assign offset_s    = bus.mem_addr[4:2];
  assign unused_s    = ^{bus.mem_addr[1:0], bus.mem_wdata[31:1]};

  // Next-state for status/enable and the read mux. A block arriving in the
  // same cycle as a CLEAR write wins, so the new data is never lost.
  always_comb begin
    data_ready_nx_s = data_ready_r;
    irq_en_nx_s     = irq_en_r;
    rdata_nx_s      = 32'h0000_0000;

    if (rx_valid_r) begin
      data_ready_nx_s = 1'b1;
    end else if (write_s && (offset_s == OFF_CLEAR)) begin
      data_ready_nx_s = 1'b0;
    end else begin
      data_ready_nx_s = data_ready_r;
    end

    if (write_s && (offset_s == OFF_IRQEN)) begin
      irq_en_nx_s = bus.mem_wdata[0];
    end else begin
      irq_en_nx_s = irq_en_r;
    end

    if (access_s && !write_s) begin
      case (offset_s)
        OFF_STATUS: rdata_nx_s = {31'd0, data_ready_r};
        OFF_DATA0:  rdata_nx_s = data_r[31:0];
        OFF_DATA1:  rdata_nx_s = data_r[63:32];
        OFF_DATA2:  rdata_nx_s = data_r[95:64];
        OFF_DATA3:  rdata_nx_s = data_r[127:96];
        OFF_IRQEN:  rdata_nx_s = {31'd0, irq_en_r};
        default:    rdata_nx_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_nx_s = 32'h0000_0000;
    end
  end

  // Registered bus response, status, enable and interrupt level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready_r  <= 1'b0;
      mem_rdata_r  <= 32'h0000_0000;
      data_ready_r <= 1'b0;
      irq_en_r     <= 1'b0;
      irq_rx_r     <= 1'b0;
    end else begin
      mem_ready_r  <= access_s;
      mem_rdata_r  <= rdata_nx_s;
      data_ready_r <= data_ready_nx_s;
      irq_en_r     <= irq_en_nx_s;
      // Built from next-state so the interrupt moves on the same edge
      // as data_ready.
      irq_rx_r     <= data_ready_nx_s & irq_en_nx_s;
    end
  end

  // Receive buffer: copy each completed block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 128'd0;
    end else if (rx_valid_r) begin
      data_r <= shift_r;
    end else begin
      data_r <= data_r;
    end
  end

  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign irq_rx        = irq_rx_r;
  assign rx_busy       = rx_busy_r;

endmodule

// File: tb/tb_spi_rx_mmio_receiver.sv
// Scoreboard bench for spi_rx_mmio_receiver: bus accesses push expected
// read data into a queue, a monitor pops and compares on every ack.
module tb_spi_rx_mmio_receiver;

  localparam logic [31:0] A_STATUS = 32'h3000_0000;
  localparam logic [31:0] A_DATA0  = 32'h3000_0004;
  localparam logic [31:0] A_DATA1  = 32'h3000_0008;
  localparam logic [31:0] A_DATA2  = 32'h3000_000C;
  localparam logic [31:0] A_DATA3  = 32'h3000_0010;
  localparam logic [31:0] A_CLEAR  = 32'h3000_0014;
  localparam logic [31:0] A_IRQEN  = 32'h3000_0018;
  localparam logic [31:0] A_RSVD   = 32'h3000_001C;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic [7:0] spi_data;
  logic       spi_cs_n;
  logic       irq_rx;
  logic       rx_busy;

  spi_rx_mmio_receiver_if bus();

  spi_rx_mmio_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk_in  (spi_clk),
    .spi_data_in (spi_data),
    .spi_cs_n_in (spi_cs_n),
    .bus         (bus),
    .irq_rx      (irq_rx),
    .rx_busy     (rx_busy)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        is_read;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] f1 [16] = '{8'h5a, 8'hc5, 8'hb4, 8'h70, 8'h80, 8'hb7, 8'hcd, 8'hd8,
                          8'h30, 8'h04, 8'h7b, 8'h6a, 8'hd8, 8'he0, 8'hc4, 8'h69};
  logic [7:0] f2 [16] = '{8'hde, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                          8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'had};
  logic [7:0] f3 [16] = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
                          8'ha8, 8'ha9, 8'haa, 8'hab, 8'hac, 8'had, 8'hae, 8'haf};
  logic [7:0] f4 [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                          8'h38, 8'h39, 8'h3a, 8'h3b, 8'h3c, 8'h3d, 8'h3e, 8'h3f};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every acknowledge consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0 && bus.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack at addr %h, expected none", bus.mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_read) begin
          check($sformatf("rdata@%h", e.addr), bus.mem_rdata, e.data);
        end
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp,
                            input logic expect_ack);
    int   cyc;
    logic got;
    @(posedge clk);
    #2;
    if (expect_ack) exp_q.push_back('{(wstrb == 4'h0), addr, exp});
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 6) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_ready === 1'b1) got = 1'b1;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    check($sformatf("ack@%h", addr), {31'd0, got}, {31'd0, expect_ack});
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_access(addr, 32'h0, 4'h0, exp, 1'b1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_access(addr, data, 4'hf, 32'h0, 1'b1);
  endtask

  // Sends n bytes (100 ns per byte) in one CS frame. With clear_on_last the
  // CLEAR write is timed to be sampled on the same edge as the block strobe.
  task automatic send_frame(input logic [7:0] b [16], input int n, input logic clear_on_last);
    @(posedge clk);
    #5 spi_cs_n = 1'b0;
    #100;
    check("rx_busy_in_frame", {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      spi_data = b[i];
      if (clear_on_last && i == n - 1) begin
        #20 spi_clk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5 spi_clk = 1'b0;
        @(posedge clk);
        #2;
        exp_q.push_back('{1'b0, A_CLEAR, 32'h0});
        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_CLEAR;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'hf;
        @(posedge clk);
        #1;
        check("simul_clear_ack", {31'd0, bus.mem_ready}, 32'd1);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        #80;
      end else begin
        #20 spi_clk = 1'b1;
        #40 spi_clk = 1'b0;
        #40;
      end
    end
    spi_cs_n = 1'b1;
    #200;
    check("rx_busy_after_frame", {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

  initial begin
    reset         = 1'b1;
    spi_clk       = 1'b0;
    spi_data      = 8'h00;
    spi_cs_n      = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("reset_mem_rdata", bus.mem_rdata, 32'h0);
    check("reset_irq_rx", {31'd0, irq_rx}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);

    rd(A_STATUS, 32'h0);
    check("irq_after_reset", {31'd0, irq_rx}, 32'd0);
    rd(A_DATA0, 32'h0);
    rd(A_DATA3, 32'h0);

    wr(A_IRQEN, 32'h1);
    rd(A_IRQEN, 32'h1);

    // First block
    send_frame(f1, 16, 1'b0);
    check("irq_after_f1", {31'd0, irq_rx}, 32'd1);
    rd(A_STATUS, 32'h1);
    rd(A_DATA0, 32'h70b4c55a);
    rd(A_DATA1, 32'hd8cdb780);
    rd(A_DATA2, 32'h6a7b0430);
    rd(A_DATA3, 32'h69c4e0d8);

    // CLEAR drops the interrupt on the ack edge
    wr(A_CLEAR, 32'h0);
    check("irq_after_clear", {31'd0, irq_rx}, 32'd0);
    rd(A_STATUS, 32'h0);
    rd(A_CLEAR, 32'h0);

    // Second block
    send_frame(f2, 16, 1'b0);
    rd(A_STATUS, 32'h1);
    rd(A_DATA0, 32'h131211de);
    rd(A_DATA1, 32'h17161514);
    rd(A_DATA2, 32'h1b1a1918);
    rd(A_DATA3, 32'had1e1d1c);

    // Short frame is discarded
    wr(A_CLEAR, 32'h0);
    send_frame(f3, 10, 1'b0);
    rd(A_STATUS, 32'h0);
    rd(A_DATA0, 32'h131211de);
    rd(A_DATA3, 32'had1e1d1c);
    check("irq_after_short", {31'd0, irq_rx}, 32'd0);

    // CLEAR coinciding with the block strobe: set wins
    send_frame(f4, 16, 1'b1);
    check("irq_after_simul", {31'd0, irq_rx}, 32'd1);
    rd(A_STATUS, 32'h1);
    rd(A_DATA0, 32'h33323130);
    rd(A_DATA3, 32'h3f3e3d3c);

    // Writes to read-only and reserved locations are ignored
    wr(A_DATA0, 32'hffff_ffff);
    rd(A_DATA0, 32'h33323130);
    wr(A_STATUS, 32'h0);
    rd(A_STATUS, 32'h1);
    wr(A_RSVD, 32'hffff_ffff);
    rd(A_RSVD, 32'h0);

    // Outside the window: no ack, no side effect
    bus_access(32'h3000_0040, 32'h0, 4'h0, 32'h0, 1'b0);
    bus_access(32'h3000_0054, 32'h0, 4'hf, 32'h0, 1'b0);
    bus_access(32'h2000_0014, 32'h0, 4'hf, 32'h0, 1'b0);
    rd(A_STATUS, 32'h1);

    // Masking the interrupt leaves the status set
    wr(A_IRQEN, 32'h0);
    check("irq_masked", {31'd0, irq_rx}, 32'd0);
    rd(A_STATUS, 32'h1);
    rd(A_IRQEN, 32'h0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
